// File: rtl/conv_enc_punc.sv
// conv_enc_punc: feed-forward rate-1/2 convolutional encoder with per-frame
// zero-tail termination and optional 2/3 and 3/4 puncturing.
// Build option: define CONV_PUNCT_EN to enable puncturing. Without it, rate_sel_i
// is ignored and every pair is transmitted in full (pure rate 1/2).
// Tap alignment: G[K-1] taps the current bit, and G[K-1-d] taps the bit from d
// beats ago. sr_q[0] holds the most recent past bit, so sr_q[i] is d = i+1.
module conv_enc_punc #(
    parameter int             K  = 7,
    parameter logic [K-1:0]   G0 = 7'o171,
    parameter logic [K-1:0]   G1 = 7'o133
) (
    input  logic        clk,
    input  logic        rst_all,
    input  logic        sof_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic        din_i,
    input  logic        in_last_i,
    input  logic [1:0]  rate_sel_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [1:0]  dout_o,
    output logic [1:0]  dout_mask_o,
    output logic        out_last_o,
    output logic        busy_o
);

    localparam int TW = $clog2(K);

    typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

    state_t          state_q;
    logic [K-2:0]    sr_q;
    logic [TW-1:0]   tail_q;
    logic            out_valid_q;
    logic [1:0]      dout_q;
    logic [1:0]      mask_q;
    logic            last_q;

    logic            advance;
    logic            accept;
    logic            sof_acc;
    logic            emit;
    logic            last_pair;
    logic            enc_bit;
    logic [K-2:0]    enc_sr;
    logic [1:0]      code;
    logic [K-2:0]    sr_d;
    logic [1:0]      mask_d;
    logic [1:0]      dout_d;

`ifdef CONV_PUNCT_EN
    logic [1:0]      rate_q;
    logic [1:0]      cnt_q;
    logic [1:0]      enc_rate;
    logic [1:0]      enc_cnt;
    logic [1:0]      cnt_d;
`else
    logic            unused_rate;
    assign unused_rate = ^rate_sel_i;
`endif

    // Parity of both generators over {current bit, history}.
    function automatic logic [1:0] encode(input logic b, input logic [K-2:0] s);
        logic a;
        logic bb;
        a  = b & G0[K-1];
        bb = b & G1[K-1];
        for (int i = 0; i < K - 1; i++) begin
            a  = a  ^ (s[i] & G0[K-2-i]);
            bb = bb ^ (s[i] & G1[K-2-i]);
        end
        return {bb, a};
    endfunction

`ifdef CONV_PUNCT_EN
    // Keep flags {B,A} for a pair at position cnt of the puncturing period.
    function automatic logic [1:0] punc_mask(input logic [1:0] rate, input logic [1:0] cnt);
        logic [1:0] m;
        case (rate)
            2'b01:   m = (cnt == 2'd0) ? 2'b11 : 2'b01;
            2'b10:   m = (cnt == 2'd0) ? 2'b11 : ((cnt == 2'd1) ? 2'b01 : 2'b10);
            default: m = 2'b11;
        endcase
        return m;
    endfunction

    // Period position after emitting one pair; rate 11 behaves as 1/2.
    function automatic logic [1:0] cnt_next(input logic [1:0] rate, input logic [1:0] cnt);
        logic [1:0] per;
        logic [1:0] nxt;
        case (rate)
            2'b01:   per = 2'd2;
            2'b10:   per = 2'd3;
            default: per = 2'd1;
        endcase
        nxt = cnt + 2'd1;
        return (nxt >= per) ? 2'd0 : nxt;
    endfunction
`endif

    assign advance     = !out_valid_q || out_ready_i;
    assign in_ready_o  = advance && (state_q != TAIL);
    assign accept      = in_valid_i && in_ready_o;
    assign sof_acc     = accept && sof_i;
    assign emit        = (state_q == TAIL) ? advance : accept;
    assign last_pair   = (state_q == TAIL) && (tail_q == '0);

    assign out_valid_o = out_valid_q;
    assign dout_o      = dout_q;
    assign dout_mask_o = mask_q;
    assign out_last_o  = last_q;
    assign busy_o      = (state_q != IDLE) || out_valid_q;

    // Encode the pair for this beat: tail beats shift in zeros, sof beats start from a clean history.
    always_comb begin
        enc_bit = (state_q == TAIL) ? 1'b0 : din_i;
        enc_sr  = sof_acc ? '0 : sr_q;
        code    = encode(enc_bit, enc_sr);
        sr_d    = {enc_sr[K-3:0], enc_bit};
`ifdef CONV_PUNCT_EN
        enc_rate = sof_acc ? rate_sel_i : rate_q;
        enc_cnt  = sof_acc ? 2'd0 : cnt_q;
        mask_d   = punc_mask(enc_rate, enc_cnt);
        cnt_d    = last_pair ? 2'd0 : cnt_next(enc_rate, enc_cnt);
`else
        mask_d   = 2'b11;
`endif
        dout_d  = code & mask_d;
    end

    // Frame FSM, history register and registered output pair.
    always_ff @(posedge clk or posedge rst_all) begin
        if (rst_all) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            tail_q      <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= 2'b00;
            mask_q      <= 2'b00;
            last_q      <= 1'b0;
`ifdef CONV_PUNCT_EN
            rate_q      <= 2'b00;
            cnt_q       <= 2'd0;
`endif
        end else begin
            if (advance) begin
                out_valid_q <= emit;
            end
            if (emit) begin
                sr_q   <= sr_d;
                dout_q <= dout_d;
                mask_q <= mask_d;
                last_q <= last_pair;
`ifdef CONV_PUNCT_EN
                cnt_q  <= cnt_d;
`endif
            end
`ifdef CONV_PUNCT_EN
            if (sof_acc) begin
                rate_q <= rate_sel_i;
            end
`endif
            case (state_q)
                IDLE, DATA: begin
                    if (accept) begin
                        if (in_last_i) begin
                            state_q <= TAIL;
                            tail_q  <= TW'(K - 2);
                        end else begin
                            state_q <= DATA;
                        end
                    end
                end
                TAIL: begin
                    if (advance) begin
                        if (tail_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            tail_q <= tail_q - 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_enc_punc.sv
// Testbench for conv_enc_punc: queued expectations from a bit-history model,
// drained by a monitor that also checks stall stability.
module tb_conv_enc_punc;

    localparam int           K  = 7;
    localparam logic [K-1:0] G0 = 7'o171;
    localparam logic [K-1:0] G1 = 7'o133;

    logic       clk = 1'b0;
    logic       rst_all = 1'b1;
    logic       sof_i = 1'b0;
    logic       in_valid_i = 1'b0;
    logic       in_ready_o;
    logic       din_i = 1'b0;
    logic       in_last_i = 1'b0;
    logic [1:0] rate_sel_i = 2'b00;
    logic       out_valid_o;
    logic       out_ready_i = 1'b1;
    logic [1:0] dout_o;
    logic [1:0] dout_mask_o;
    logic       out_last_o;
    logic       busy_o;

    typedef struct packed {
        logic [1:0] d;
        logic [1:0] m;
        logic       l;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   ready_rand = 1'b0;
    bit   fb [0:127];

    conv_enc_punc #(.K(K), .G0(G0), .G1(G1)) dut (
        .clk         (clk),
        .rst_all     (rst_all),
        .sof_i       (sof_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .din_i       (din_i),
        .in_last_i   (in_last_i),
        .rate_sel_i  (rate_sel_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .dout_o      (dout_o),
        .dout_mask_o (dout_mask_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_mask(input logic [1:0] rate, input int j);
`ifdef CONV_PUNCT_EN
        case (rate)
            2'b01:   return (j % 2 == 0) ? 2'b11 : 2'b01;
            2'b10:   return (j % 3 == 0) ? 2'b11 : ((j % 3 == 1) ? 2'b01 : 2'b10);
            default: return 2'b11;
        endcase
`else
        return (rate === 2'bxx && j < 0) ? 2'b00 : 2'b11;
`endif
    endfunction

    // Pair j of a frame = XOR over taps d of G[K-1-d] * bit[j-d]; bits past n are tail zeros.
    task automatic model_frame(input int n, input logic [1:0] rate, input bit tail);
        int   total;
        logic a, b;
        logic [1:0] m;
        exp_t e;
        total = tail ? n + K - 1 : n;
        for (int j = 0; j < total; j++) begin
            a = 1'b0;
            b = 1'b0;
            for (int d = 0; d < K; d++) begin
                if (j - d >= 0 && j - d < n && fb[j-d]) begin
                    a = a ^ G0[K-1-d];
                    b = b ^ G1[K-1-d];
                end
            end
            m   = exp_mask(rate, j);
            e.d = {b, a} & m;
            e.m = m;
            e.l = tail && (j == total - 1);
            sb.push_back(e);
        end
    endtask

    task automatic send_bit(input bit s, input bit d, input bit l, input logic [1:0] r);
        int guard;
        guard = 0;
        @(negedge clk);
        #1;
        sof_i      = s;
        din_i      = d;
        in_last_i  = l;
        rate_sel_i = s ? r : 2'($urandom_range(0, 3));
        in_valid_i = 1'b1;
        forever begin
            #1;
            if (in_ready_o) begin
                @(posedge clk);
                break;
            end
            guard++;
            if (guard > 1000) begin
                check("in_ready_timeout", 32'(in_ready_o), 32'd1);
                break;
            end
            @(negedge clk);
            #1;
        end
        #1;
        in_valid_i = 1'b0;
        sof_i      = 1'b0;
        in_last_i  = 1'b0;
    endtask

    task automatic drive_frame(input int n, input logic [1:0] rate, input bit last);
        for (int i = 0; i < n; i++) begin
            send_bit(i == 0, fb[i], last && (i == n - 1), rate);
        end
    endtask

    task automatic rand_bits(input int n, input bit ones);
        for (int i = 0; i < n; i++) fb[i] = ones ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string name);
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drained"}, 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);
        #1;
        check({name, "_idle_busy"}, 32'(busy_o), 32'd0);
    endtask

    // Monitor: pops an expectation on each handshake and checks stability while stalled.
    initial begin
        bit   hold_prev;
        exp_t held;
        exp_t e;
        hold_prev = 1'b0;
        held      = '0;
        forever begin
            @(negedge clk);
            if (rst_all) begin
                hold_prev = 1'b0;
            end else begin
                if (hold_prev) begin
                    check("stall_valid", 32'(out_valid_o), 32'd1);
                    check("stall_data", 32'({dout_o, dout_mask_o, out_last_o}), 32'(held));
                end
                out_ready_i = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
                if (out_valid_o && out_ready_i) begin
                    if (sb.size() == 0) begin
                        check("unexpected_pair", 32'(out_valid_o), 32'd0);
                    end else begin
                        e = sb.pop_front();
                        check("dout", 32'(dout_o), 32'(e.d));
                        check("dout_mask", 32'(dout_mask_o), 32'(e.m));
                        check("out_last", 32'(out_last_o), 32'(e.l));
                    end
                end
                hold_prev = out_valid_o && !out_ready_i;
                held      = {dout_o, dout_mask_o, out_last_o};
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] imp [0:6];
        exp_t       e;
        logic [1:0] r;
        int         n;
        imp[0] = 2'b11; imp[1] = 2'b01; imp[2] = 2'b11; imp[3] = 2'b11;
        imp[4] = 2'b00; imp[5] = 2'b10; imp[6] = 2'b11;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_dout", 32'(dout_o), 32'd0);
        check("rst_mask", 32'(dout_mask_o), 32'd0);
        check("rst_last", 32'(out_last_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        @(negedge clk);
        rst_all = 1'b0;

        // Test 1: impulse against the literal response
        ready_rand = 1'b0;
        for (int i = 0; i < 7; i++) begin
            e.d = imp[i]; e.m = 2'b11; e.l = (i == 6);
            sb.push_back(e);
        end
        send_bit(1'b1, 1'b1, 1'b1, 2'b00);
        drain("impulse");

        // Test 2: 64 random bits under random backpressure
        ready_rand = 1'b1;
        rand_bits(64, 1'b0);
        model_frame(64, 2'b00, 1'b1);
        drive_frame(64, 2'b00, 1'b1);
        drain("backpressure");

        // Test 3: six ones at rate 3/4
        ready_rand = 1'b0;
        rand_bits(6, 1'b1);
        model_frame(6, 2'b10, 1'b1);
        drive_frame(6, 2'b10, 1'b1);
        drain("rate34");

        // Test 4: back-to-back impulses, in_ready low during the tail
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 7; i++) begin
                e.d = imp[i]; e.m = 2'b11; e.l = (i == 6);
                sb.push_back(e);
            end
            send_bit(1'b1, 1'b1, 1'b1, 2'b00);
            for (int c = 0; c < 6; c++) begin
                @(negedge clk);
                #1;
                check("tail_in_ready", 32'(in_ready_o), 32'd0);
            end
            @(negedge clk);
            #1;
            check("post_tail_in_ready", 32'(in_ready_o), 32'd1);
        end
        drain("b2b");

        // Test 5: reset in the middle of the tail
        fb[0] = 1'b1;
        model_frame(1, 2'b00, 1'b1);
        send_bit(1'b1, 1'b1, 1'b1, 2'b00);
        repeat (3) @(negedge clk);
        #1;
        rst_all = 1'b1;
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_all = 1'b0;
        @(negedge clk);
        #1;
        check("midtail_rst_valid", 32'(out_valid_o), 32'd0);
        check("midtail_rst_busy", 32'(busy_o), 32'd0);
        check("midtail_rst_in_ready", 32'(in_ready_o), 32'd1);
        rand_bits(12, 1'b0);
        model_frame(12, 2'b01, 1'b1);
        drive_frame(12, 2'b01, 1'b1);
        drain("after_rst");

        // Test 6: sof at bit 10 of 20 truncates the first frame
        ready_rand = 1'b1;
        rand_bits(10, 1'b0);
        model_frame(10, 2'b10, 1'b0);
        drive_frame(10, 2'b10, 1'b0);
        rand_bits(10, 1'b0);
        model_frame(10, 2'b10, 1'b1);
        drive_frame(10, 2'b10, 1'b1);
        drain("truncate");

        // Random frames of random length and rate
        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 24);
            r = 2'($urandom_range(0, 3));
            rand_bits(n, 1'b0);
            model_frame(n, r, 1'b1);
            drive_frame(n, r, 1'b1);
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
